// File: rtl/la_probe_pkg.sv
// Shared constants for the logic-analyzer counter probe:
// LA bit positions, pad offsets and firmware status codes.
package la_probe_pkg;

    localparam int CNT_LO    = 32;
    localparam int EN_BIT    = 64;
    localparam int SRST_BIT  = 65;
    localparam int CHK_LO    = 96;
    localparam int CHK_STB   = 112;
    localparam int CHK_IO_LO = 16;
    localparam int CHK_LA_LO = 32;
    localparam int IOI_LO    = 32;
    localparam int IOI_W     = 6;

    localparam logic [15:0] ST_START = 16'hAB60;
    localparam logic [15:0] ST_PASS  = 16'hAB61;

endpackage

// File: rtl/la_counter_probe_if.sv
// LA and GPIO pad bundle between the management SoC and the probe.
// The probe takes the slave side; firmware/harness takes the master side.
interface la_counter_probe_if;

    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;
    logic [37:0]  io_in;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    logic [2:0]   irq;

    modport master (
        output la_data_in, la_oenb, io_in,
        input  la_data_out, io_out, io_oeb, irq
    );

    modport slave (
        input  la_data_in, la_oenb, io_in,
        output la_data_out, io_out, io_oeb, irq
    );

endinterface

// File: rtl/la_probe_counter.sv
// Free-running counter with enable, per-bit preset and
// increment-wrap detect (preset-caused wraps are not flagged).
module la_probe_counter #(
    parameter int BITS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [BITS-1:0] wr_i,
    input  logic [BITS-1:0] din_i,
    output logic [BITS-1:0] count_o,
    output logic            wrap_o
);

    logic [BITS-1:0] count_q;
    logic [BITS-1:0] count_d;
    logic [BITS-1:0] inc;

    // Carry comes from the old count; preset bits then override.
    always_comb begin
        inc     = en_i ? count_q + BITS'(1) : count_q;
        count_d = (wr_i & din_i) | (~wr_i & inc);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = en_i & (&count_q) & ~(|wr_i);

endmodule

// File: rtl/la_counter_probe.sv
// LA-controlled counter probe with status word on io[31:16].
// Define LA_PROBE_IRQ_EN to enable wrap/status-write interrupts.
module la_counter_probe
    import la_probe_pkg::*;
#(
    parameter int                   BITS        = 32,
    parameter int                   CHECK_W     = 16,
    parameter logic [CHECK_W-1:0]   RESET_CHECK = '0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    la_counter_probe_if.slave bus
);

    logic               srst;
    logic               en;
    logic               chk_wr;
    logic               wrap;
    logic [BITS-1:0]    wr;
    logic [BITS-1:0]    din;
    logic [BITS-1:0]    count;
    logic [31:0]        cnt32;
    logic [CHECK_W-1:0] check_q;
    logic [CHECK_W-1:0] check_d;

    // Hard reset and LA soft reset share one path.
    assign srst   = wb_rst_i
                  | (~bus.la_oenb[SRST_BIT] & bus.la_data_in[SRST_BIT]);
    assign en     = bus.la_oenb[EN_BIT] | bus.la_data_in[EN_BIT];
    assign wr     = ~bus.la_oenb[CNT_LO +: BITS];
    assign din    = bus.la_data_in[CNT_LO +: BITS];
    assign chk_wr = ~bus.la_oenb[CHK_STB] & bus.la_data_in[CHK_STB];

    la_probe_counter #(
        .BITS (BITS)
    ) u_cnt (
        .clk_i   (wb_clk_i),
        .rst_i   (srst),
        .en_i    (en),
        .wr_i    (wr),
        .din_i   (din),
        .count_o (count),
        .wrap_o  (wrap)
    );

    assign check_d = chk_wr ? bus.la_data_in[CHK_LO +: CHECK_W] : check_q;

    always_ff @(posedge wb_clk_i) begin
        if (srst) begin
            check_q <= RESET_CHECK;
        end else begin
            check_q <= check_d;
        end
    end

`ifdef LA_PROBE_IRQ_EN
    logic [1:0] irq_q;
    logic [1:0] irq_d;

    assign irq_d = {chk_wr, wrap};

    always_ff @(posedge wb_clk_i) begin
        if (srst) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = {1'b0, irq_q};
`else
    assign bus.irq = 3'b000;
`endif

    assign cnt32 = 32'(count);

    always_comb begin
        bus.la_data_out                        = '0;
        bus.la_data_out[31:0]                  = cnt32;
        bus.la_data_out[CHK_LA_LO +: CHECK_W]  = check_q;
        bus.la_data_out[CHK_LO +: IOI_W]       = bus.io_in[IOI_LO +: IOI_W];
        bus.io_out                             = '0;
        bus.io_out[CHK_IO_LO +: CHECK_W]       = check_q;
        bus.io_out[15:0]                       = cnt32[15:0];
        bus.io_oeb                             = {6'h3F, 32'h0};
    end

endmodule

// File: tb/tb_la_counter_probe.sv
// Randomized and directed bench for la_counter_probe against a
// behavioural model of the counter, status word and interrupts.
module tb_la_counter_probe;
    import la_probe_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] m_cnt;
    logic [15:0] m_chk;
    logic [2:0]  m_irq;

    la_counter_probe_if bus();

    la_counter_probe dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(string tag, logic [127:0] got,
                            logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [127:0] d;
        logic [127:0] o;
        logic [31:0]  nxt;
        logic         en;
        logic         wrap;
        logic         cw;
        d = bus.la_data_in;
        o = bus.la_oenb;
        if (rst || (!o[65] && d[65])) begin
            m_cnt = 0;
            m_chk = 16'h0000;
            m_irq = 3'b000;
        end else begin
            en   = o[64] | d[64];
            wrap = en && (m_cnt == 32'hFFFF_FFFF)
                   && (o[63:32] == 32'hFFFF_FFFF);
            nxt  = en ? m_cnt + 32'd1 : m_cnt;
            for (int i = 0; i < 32; i++)
                if (!o[32+i]) nxt[i] = d[32+i];
            cw = !o[112] && d[112];
            if (cw) m_chk = d[111:96];
            m_cnt = nxt;
`ifdef LA_PROBE_IRQ_EN
            m_irq = {1'b0, cw, wrap};
`else
            m_irq = 3'b000;
`endif
        end
    endtask

    task automatic cycle();
        logic [127:0] exp;
        @(posedge clk);
        model_step();
        #1;
        exp          = '0;
        exp[31:0]    = m_cnt;
        exp[47:32]   = m_chk;
        exp[101:96]  = bus.io_in[37:32];
        check_eq("la_out", bus.la_data_out, exp);
        check_eq("io_out", 128'(bus.io_out),
                 128'({6'b0, m_chk, m_cnt[15:0]}));
        check_eq("io_oeb", 128'(bus.io_oeb), 128'(38'h3F_0000_0000));
        check_eq("irq", 128'(bus.irq), 128'(m_irq));
    endtask

    task automatic idle();
        bus.la_oenb    = '1;
        bus.la_data_in = '0;
    endtask

    task automatic preset(logic [31:0] v);
        bus.la_oenb[63:32]    = '0;
        bus.la_data_in[63:32] = v;
    endtask

    task automatic status(logic [15:0] v);
        bus.la_oenb[112:96]    = '0;
        bus.la_data_in[112:96] = {1'b1, v};
    endtask

    initial begin
        int irq_n;
        int exp_irq;
        total = 0;
        bad   = 0;
        m_cnt = 0;
        m_chk = 0;
        m_irq = 0;
        rst   = 1'b1;
        bus.io_in = 38'($urandom);
        idle();
        cycle();
        cycle();
        rst = 1'b0;
        check_eq("rst_cnt", 128'(bus.la_data_out[31:0]), 128'(0));

        // 1: free run
        repeat (10) cycle();
        check_eq("run10", 128'(bus.la_data_out[31:0]), 128'(10));
        check_eq("chk0", 128'(bus.io_out[31:16]), 128'(16'h0000));

        // 2: status writes
        status(ST_START);
        cycle();
        idle();
        check_eq("st_start", 128'(bus.io_out[31:16]), 128'(ST_START));
        status(ST_PASS);
        cycle();
        idle();
        check_eq("st_pass", 128'(bus.io_out[31:16]), 128'(ST_PASS));

        // 3: preset near wrap
        preset(32'hFFFF_FFF0);
        cycle();
        idle();
        check_eq("pre_f0", 128'(bus.la_data_out[31:0]),
                 128'(32'hFFFF_FFF0));
        irq_n = 0;
        for (int i = 0; i < 17; i++) begin
            cycle();
            if (i == 15)
                check_eq("wrap0", 128'(bus.la_data_out[31:0]), 128'(0));
            if (bus.irq[0]) irq_n++;
        end
`ifdef LA_PROBE_IRQ_EN
        exp_irq = 1;
`else
        exp_irq = 0;
`endif
        check_eq("irq_n", 128'(irq_n), 128'(exp_irq));

        // 4: partial preset of bit 0
        preset(32'd5);
        cycle();
        idle();
        bus.la_oenb[32] = 1'b0;
        cycle();
        check_eq("part6", 128'(bus.la_data_out[31:0]), 128'(6));
        cycle();
        idle();
        check_eq("part6b", 128'(bus.la_data_out[31:0]), 128'(6));

        // 5: freeze
        bus.la_oenb[64] = 1'b0;
        repeat (20) cycle();
        check_eq("frz", 128'(bus.la_data_out[31:0]), 128'(6));
        idle();
        cycle();
        check_eq("resume", 128'(bus.la_data_out[31:0]), 128'(7));

        // 6: simultaneous preset+status, soft reset, hard reset wins
        preset(32'h1234);
        status(ST_START);
        cycle();
        idle();
        check_eq("sim_cnt", 128'(bus.la_data_out[31:0]), 128'(32'h1234));
        check_eq("sim_chk", 128'(bus.io_out[31:16]), 128'(ST_START));
        bus.la_oenb[65]    = 1'b0;
        bus.la_data_in[65] = 1'b1;
        cycle();
        idle();
        check_eq("srst_cnt", 128'(bus.la_data_out[31:0]), 128'(0));
        check_eq("srst_chk", 128'(bus.io_out[31:16]), 128'(0));
        rst = 1'b1;
        status(ST_PASS);
        cycle();
        rst = 1'b0;
        idle();
        check_eq("rst_win", 128'(bus.io_out[31:16]), 128'(0));

        // random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            bus.io_in = {6'($urandom), 32'($urandom)};
            bus.la_data_in = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 9) == 0) bus.la_oenb[64] = 1'b0;
            if ($urandom_range(0, 39) == 0) bus.la_oenb[65] = 1'b0;
            if ($urandom_range(0, 4) == 0) bus.la_oenb[112] = 1'b0;
            case ($urandom_range(0, 9))
                0: bus.la_oenb[63:32] = '0;
                1: bus.la_oenb[63:32] = $urandom;
                2: begin
                    bus.la_oenb[63:32]    = '0;
                    bus.la_data_in[63:32] = 32'hFFFF_FFF0
                                          | 32'($urandom_range(0, 15));
                end
                default: ;
            endcase
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
